// File: rtl/wb_retire_queue_if.sv
// Bundle of signals between the memory stage, the write-back retire queue,
// the register-file write port and the decode forwarding lookups.
interface wb_retire_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int NUM_LOOKUP = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Memory-stage input side
    logic                             in_valid;
    logic                             in_ready;
    logic                             in_uses_rw;
    logic [ADDR_WIDTH-1:0]            in_rw_addr;
    logic [DATA_WIDTH-1:0]            in_rw_data;

    // Register-file write side
    logic                             out_valid;
    logic                             out_ready;
    logic [ADDR_WIDTH-1:0]            out_rw_addr;
    logic [DATA_WIDTH-1:0]            out_rw_data;

    // Forwarding lookups
    logic [NUM_LOOKUP*ADDR_WIDTH-1:0] lookup_addr;
    logic [NUM_LOOKUP-1:0]            lookup_hit;
    logic [NUM_LOOKUP*DATA_WIDTH-1:0] lookup_data;

    // Status
    logic [CW-1:0]                    count;
    logic                             empty;

    // Pipeline side: drives requests, observes the queue
    modport master (
        output in_valid, in_uses_rw, in_rw_addr, in_rw_data,
        output out_ready, lookup_addr,
        input  in_ready, out_valid, out_rw_addr, out_rw_data,
        input  lookup_hit, lookup_data, count, empty
    );

    // Queue side
    modport slave (
        input  in_valid, in_uses_rw, in_rw_addr, in_rw_data,
        input  out_ready, lookup_addr,
        output in_ready, out_valid, out_rw_addr, out_rw_data,
        output lookup_hit, lookup_data, count, empty
    );
endinterface

// File: rtl/wb_retire_queue.sv
// Write-back retire queue: buffers completed results between the memory
// stage and the register-file write port, and forwards the newest pending
// value of a register to decode so it never reads stale data.
module wb_retire_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int NUM_LOOKUP = 2
) (
    input  logic               clk,
    input  logic               rst,
    wb_retire_queue_if.slave   wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage is kept in flops: every entry must be visible to the
    // forwarding search in the same cycle, and it resets to zero.
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic accept;
    logic store;
    logic deq;

    // Full is decided purely from the registered count; a dequeue in the
    // same cycle does not open the input (keeps in_ready off long paths).
    assign wb.in_ready    = (count_q < CW'(DEPTH));
    assign wb.empty       = (count_q == '0);
    assign wb.out_valid   = ~wb.empty;
    assign wb.count       = count_q;
    assign wb.out_rw_addr = addr_q[head_q];
    assign wb.out_rw_data = data_q[head_q];

    // Writes to r0 or non-writing results complete the handshake but are
    // dropped, since they can never affect the register file.
    assign accept = wb.in_valid & wb.in_ready;
    assign store  = accept & wb.in_uses_rw & (wb.in_rw_addr != '0);
    assign deq    = wb.out_valid & wb.out_ready;

    // Pointer and occupancy next-state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (store) begin
            tail_d = tail_q + PW'(1);
        end
        if (deq) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(store) - CW'(deq);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written at the tail
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Per-entry register: cleared on reset, loaded when the tail points here
            always_ff @(posedge clk) begin
                if (rst) begin
                    addr_q[gi] <= '0;
                    data_q[gi] <= '0;
                end else if (store && (tail_q == PW'(gi))) begin
                    addr_q[gi] <= wb.in_rw_addr;
                    data_q[gi] <= wb.in_rw_data;
                end
            end
        end
    endgenerate

    // Forwarding lookups
    logic [NUM_LOOKUP-1:0] hit_w;
    logic [DATA_WIDTH-1:0] fwd_w [NUM_LOOKUP];

    generate
        for (genvar gi = 0; gi < NUM_LOOKUP; gi++) begin : g_lookup
            logic [ADDR_WIDTH-1:0] key;
            assign key = wb.lookup_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

            // Newest-first search: the incoming store wins, then stored
            // entries from tail-1 back toward head. The loop runs oldest to
            // newest so later (newer) matches overwrite earlier ones.
            always_comb begin
                logic [PW-1:0] idx;
                hit_w[gi] = 1'b0;
                fwd_w[gi] = '0;
                idx       = '0;
                if (key != '0) begin
                    for (int j = DEPTH - 1; j >= 0; j--) begin
                        idx = tail_q - PW'(j + 1);
                        if ((CW'(j) < count_q) && (addr_q[idx] == key)) begin
                            hit_w[gi] = 1'b1;
                            fwd_w[gi] = data_q[idx];
                        end
                    end
                    if (store && (wb.in_rw_addr == key)) begin
                        hit_w[gi] = 1'b1;
                        fwd_w[gi] = wb.in_rw_data;
                    end
                end
            end

            assign wb.lookup_hit[gi]                            = hit_w[gi];
            assign wb.lookup_data[gi*DATA_WIDTH +: DATA_WIDTH]  = fwd_w[gi];
        end
    endgenerate
endmodule

// File: doc/wb_retire_queue.md
# wb_retire_queue

Parametrised write-back retire queue between the memory-stage output and the register-file write port. It buffers completed results (uses_rw, rw_addr, rw_data) in a DEPTH-entry FIFO so the memory stage can keep completing while the register-file port is busy. It provides NUM_LOOKUP combinational forwarding ports that return the newest pending value for a register, so decode never reads stale data. Backpressure (in_ready low) is the stall source for the memory stage when the queue is full.

## Interface
- DATA_WIDTH, 32, width of rw_data
- ADDR_WIDTH, 5, width of register address
- DEPTH, 4, queue entries; power of two, >= 2
- NUM_LOOKUP, 2, number of forwarding lookup ports (rs/rt)
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- in_valid  input  1  memory stage offers a result
- in_ready  output  1  queue can accept; high when count < DEPTH
- in_uses_rw  input  1  result writes a register
- in_rw_addr  input  ADDR_WIDTH  destination register
- in_rw_data  input  DATA_WIDTH  result value
- out_valid  output  1  head entry pending for register file
- out_ready  input  1  register file accepts head this cycle
- out_rw_addr  output  ADDR_WIDTH  head destination
- out_rw_data  output  DATA_WIDTH  head value
- lookup_addr  input  NUM_LOOKUP*ADDR_WIDTH  packed lookup addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- lookup_hit  output  NUM_LOOKUP  port k found a pending write
- lookup_data  output  NUM_LOOKUP*DATA_WIDTH  forwarded value, packed as lookup_addr
- count  output  $clog2(DEPTH)+1  stored entries
- empty  output  1  count == 0

## Operation
- Accept when in_valid & in_ready. If in_uses_rw == 0 or in_rw_addr == 0, handshake completes but nothing is stored.
- Stored entries are written at tail; tail advances by 1 modulo DEPTH.
- Dequeue when out_valid & out_ready; head advances by 1 modulo DEPTH. out_valid = ~empty. out_rw_addr/out_rw_data come from the head registers.
- Simultaneous store and dequeue: count unchanged; both pointers advance.
- in_ready depends only on registered count; it does not look ahead at out_ready. A full queue with a dequeue this cycle still shows in_ready = 0.
- Forwarding port k: lookup_addr == 0 never hits.
  - Highest priority: a storing input this cycle (in_valid & in_ready & in_uses_rw & matching addr) returns in_rw_data.
  - Otherwise: the newest stored entry with matching addr, searched tail-1 toward head.
  - An entry being dequeued this cycle is still searchable.
  - No match: lookup_hit = 0, lookup_data = 0.
- Same register written twice: both entries are stored and retired in order; lookup returns the newer one.
- Storage (addr, data) resets to 0; head, tail and count reset to 0.
- rst mid-operation discards all pending entries; nothing is retired in the reset cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, out_rw_addr=0, out_rw_data=0, lookup_hit=0, lookup_data=0, count=0, empty=1.
- Latency: an entry stored at edge N appears at out on cycle N+1. Throughput: one store and one retire per cycle.
- Lookup is purely combinational from the lookup/in ports and registered state, with no cycle delay.
- count, empty and in_ready update on the clock edge after a handshake.
- Pointer wrap: after DEPTH stores with no dequeues, tail == head and count == DEPTH; full and empty are distinguished by count.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, empty=1, count=0, both lookup_hit=0.
- Store r5=0x11, r6=0x22 with out_ready=0 -> count=2, out_rw_addr=5, out_rw_data=0x11. Lookup r6 -> hit, 0x22. Lookup r7 -> no hit.
- Fill with DEPTH=4 entries -> in_ready=0, and the next in_valid is held. Raise out_ready for one cycle: count goes 4->3, in_ready=1 the following cycle. Retire order matches store order.
- Store r3=0xA, then r3=0xB. Lookup r3 -> 0xB. Offer r3=0xC on in_* the same cycle -> lookup returns 0xC.
- in_rw_addr=0 or in_uses_rw=0 with in_valid -> handshake completes, count unchanged. Lookup of r0 never hits.
- Hold in_valid and out_ready high continuously for 3*DEPTH cycles -> count stays 1, values retire in order across the pointer wrap. Assert rst mid-stream -> the next cycle shows the reset values.
